if_capture_buffer: RTL and testbench

- Snapshot buffer for the raw 2-bit GPS IF stream (IF_SGN/IF_MAG) sampled on the 16.368 MHz gps clock.
- Sits directly upstream of the CPU parallel-port mux: packs samples into 16-bit words and holds them in a FIFO; the CPU drains it one word at a time.
- Used for acquisition debugging and host-side FFT search.
- Raises a service request when a capture of the programmed length completes.

---
 rtl/if_capture_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_if_capture_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_capture_buffer.sv
// Snapshot buffer for the 2-bit GPS IF stream: packs eight {mag,sgn} samples per
// 16-bit word into a FIFO that the CPU drains one word per rd pulse.
module if_capture_buffer #(
    parameter int DEPTH_LOG2  = 10,
    parameter int SRQ_ON_DONE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_sgn,
    input  logic                  if_mag,
    input  logic                  arm,
    input  logic [DEPTH_LOG2:0]   len,
    input  logic                  rd,
    input  logic                  clr,
    output logic [15:0]           dout,
    output logic [15:0]           status,
    output logic                  srq,
    output logic [1:0]            dbg_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    // Debug encoding: 0 = idle, 1 = filling, 2 = capture done.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2:0]   words_left_q, words_left_d;
    logic [DEPTH_LOG2:0]   len_clamped;
    logic [2:0]            k_q, k_d;
    logic [13:0]           shift_q, shift_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [15:0]           dout_q, dout_d;
    logic [15:0]           mem [DEPTH];

    logic [1:0]  sample;
    logic [15:0] word;
    logic        busy, done;
    logic        fifo_full, fifo_empty;
    logic        word_done, arm_ok, push, pop, rd_empty, dout_load;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr outranks every other event in the cycle
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d = (len_clamped == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (word_done && (fifo_full || words_left_q == CNT_ONE)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        busy = (state_q == S_FILL);
        done = (state_q == S_DONE);
    end

    always_comb begin
        sample      = {if_mag, if_sgn};
        word        = {sample, shift_q};
        len_clamped = (len > DEPTH_CNT) ? DEPTH_CNT : len;
        fifo_full   = (count_q == DEPTH_CNT);
        fifo_empty  = (count_q == '0);
        word_done   = busy && (k_q == 3'd7);
        arm_ok      = arm && !clr && !busy;
        push        = word_done && !fifo_full && !clr;
        pop         = rd && !fifo_empty && !clr;
        rd_empty    = rd && fifo_empty && !clr;
        dout_load   = pop || (push && fifo_empty);
    end

    // Shift right so that after seven samples sample 0 sits in bits [1:0];
    // the eighth sample completes the word straight from the input pins.
    always_comb begin
        shift_d      = shift_q;
        k_d          = k_q;
        words_left_d = words_left_q;
        if (busy) begin
            shift_d = {sample, shift_q[13:2]};
            k_d     = k_q + 3'd1;
        end
        if (push) begin
            words_left_d = words_left_q - CNT_ONE;
        end
        if (arm_ok) begin
            k_d          = 3'd0;
            words_left_d = len_clamped;
        end
        if (clr) begin
            k_d          = 3'd0;
            words_left_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (word_done && fifo_full) ovf_d = 1'b1;
            if (rd_empty)               udf_d = 1'b1;
        end
    end

    // A word written this edge into the slot the head is moving to is forwarded.
    always_comb begin
        dout_d = dout_q;
        if (clr) begin
            dout_d = '0;
        end else if (dout_load) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                dout_d = word;
            end else begin
                dout_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            words_left_q <= '0;
            k_q          <= 3'd0;
            shift_q      <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            dout_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            words_left_q <= words_left_d;
            k_q          <= k_d;
            shift_q      <= shift_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            dout_q       <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= word;
        end
    end

    always_comb begin
        dout        = dout_q;
        status      = {busy, done, ovf_q, udf_q, 1'b0, 11'(count_q)};
        srq         = (SRQ_ON_DONE != 0) && done && !fifo_empty;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_if_capture_buffer.sv
// Bench for if_capture_buffer (8-word FIFO): directed vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a queue model.
module tb_if_capture_buffer;

    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;
    localparam int LW    = DL2 + 1;

    logic          clk;
    logic          rst;
    logic          if_sgn;
    logic          if_mag;
    logic          arm;
    logic [LW-1:0] len;
    logic          rd;
    logic          clr;
    logic [15:0]   dout;
    logic [15:0]   status;
    logic          srq;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    if_capture_buffer #(.DEPTH_LOG2(DL2), .SRQ_ON_DONE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_sgn      (if_sgn),
        .if_mag      (if_mag),
        .arm         (arm),
        .len         (len),
        .rd          (rd),
        .clr         (clr),
        .dout        (dout),
        .status      (status),
        .srq         (srq),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, samples collected until eight make a word
    typedef enum {M_IDLE, M_FILL, M_DONE} mstate_t;
    mstate_t     m_state;
    logic [15:0] exp_q[$];
    logic [1:0]  smp_q[$];
    int          words_left;
    bit          m_ovf, m_udf, m_dout_zero;

    task automatic model_step(input bit a, input int l, input bit r, input bit c, input logic [1:0] s);
        bit push_w, pop_w;
        logic [15:0] w;
        push_w = 0;
        pop_w  = 0;
        w      = '0;
        if (!rst || c) begin
            m_state = M_IDLE;
            exp_q.delete();
            smp_q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_dout_zero = 1;
            words_left = 0;
            return;
        end
        if (m_state == M_FILL) begin
            smp_q.push_back(s);
            if (smp_q.size() == 8) begin
                for (int i = 0; i < 8; i++) w = w | (16'(smp_q[i]) << (2 * i));
                smp_q.delete();
                if (exp_q.size() == DEPTH) begin
                    m_ovf = 1;
                    m_state = M_DONE;
                end else begin
                    push_w = 1;
                    words_left--;
                    if (words_left == 0) m_state = M_DONE;
                end
            end
        end else if (a) begin
            words_left = (l > DEPTH) ? DEPTH : l;
            smp_q.delete();
            m_state = (words_left == 0) ? M_DONE : M_FILL;
        end
        if (r) begin
            if (exp_q.size() > 0) pop_w = 1;
            else m_udf = 1;
        end
        if (pop_w) void'(exp_q.pop_front());
        if (push_w) begin
            exp_q.push_back(w);
            m_dout_zero = 0;
        end
    endtask

    // Scoreboard
    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] es;
        es = {m_state == M_FILL, m_state == M_DONE, m_ovf, m_udf, 1'b0, 11'(exp_q.size())};
        check16({tag, ":status"}, status, es);
        check16({tag, ":srq"}, 16'(srq), 16'(m_state == M_DONE && exp_q.size() != 0));
        check16({tag, ":active"}, 16'(dbg_state != 2'd0), 16'(m_state != M_IDLE));
        if (exp_q.size() != 0) check16({tag, ":dout"}, dout, exp_q[0]);
        else if (m_dout_zero) check16({tag, ":dout0"}, dout, 16'h0000);
    endtask

    // Driver: inputs change at negedge, outputs sampled 1 time unit after posedge
    task automatic tick(input bit a, input int l, input bit r, input bit c,
                        input logic [1:0] s, input bit chk, input string tag);
        arm    = a;
        len    = LW'(l);
        rd     = r;
        clr    = c;
        if_mag = s[1];
        if_sgn = s[0];
        model_step(a, l, r, c, s);
        @(posedge clk);
        #1;
        if (chk) check_model(tag);
        @(negedge clk);
        arm = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n;
        bit          rst_n;
        bit          a;
        int          l;
        bit          r;
        bit          c;
        logic [1:0]  s;
        logic [15:0] st;
        bit          sq;
        bit          chk_dout;
        logic [15:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, int n, bit rn, bit a, int l, bit r, bit c,
                                logic [1:0] s, logic [15:0] st, bit sq, bit cd, logic [15:0] d);
        vec_t v;
        v.name = nm; v.n = n; v.rst_n = rn; v.a = a; v.l = l; v.r = r; v.c = c;
        v.s = s; v.st = st; v.sq = sq; v.chk_dout = cd; v.d = d;
        return v;
    endfunction

    logic [1:0]  pp_s[64];
    logic [15:0] pp_w[8];
    bit          prev_rd;
    int          rd_div;
    logic [1:0]  ord[8];

    initial begin
        rst = 1'b0; arm = 1'b0; len = '0; rd = 1'b0; clr = 1'b0;
        if_sgn = 1'b0; if_mag = 1'b0;
        prev_rd = 0;
        ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3;
        ord[4] = 2'd0; ord[5] = 2'd1; ord[6] = 2'd2; ord[7] = 2'd3;

        //             name            n  rst a  len rd clr smp    status    srq cd dout
        vecs.push_back(mk("reset",      2, 0, 0, 0,  0, 0, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("arm2",       1, 1, 1, 2,  0, 0, 2'd1, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("fill15",    15, 1, 0, 0,  0, 0, 2'd1, 16'h8001, 0, 1, 16'h5555));
        vecs.push_back(mk("fill_done",  1, 1, 0, 0,  0, 0, 2'd1, 16'h4002, 1, 1, 16'h5555));
        vecs.push_back(mk("rd_a",       1, 1, 0, 0,  1, 0, 2'd0, 16'h4001, 1, 1, 16'h5555));
        vecs.push_back(mk("gap",        1, 1, 0, 0,  0, 0, 2'd0, 16'h4001, 1, 1, 16'h5555));
        vecs.push_back(mk("rd_b",       1, 1, 0, 0,  1, 0, 2'd0, 16'h4000, 0, 0, 16'h0000));
        vecs.push_back(mk("clr_a",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("udf",        1, 1, 0, 0,  1, 0, 2'd0, 16'h1000, 0, 1, 16'h0000));
        vecs.push_back(mk("clr_b",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("ord_arm",    1, 1, 1, 1,  0, 0, 2'd0, 16'h8000, 0, 1, 16'h0000));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk("ord_fill", 1, 1, 0, 0, 0, 0, ord[i], 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("ord_word",   1, 1, 0, 0,  0, 0, ord[7], 16'h4001, 1, 1, 16'hE4E4));
        vecs.push_back(mk("ord_rd",     1, 1, 0, 0,  1, 0, 2'd0, 16'h4000, 0, 0, 16'h0000));
        vecs.push_back(mk("clr_c",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("len0",       1, 1, 1, 0,  0, 0, 2'd0, 16'h4000, 0, 1, 16'h0000));
        vecs.push_back(mk("clr_d",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("pri_arm",    1, 1, 1, 4,  0, 0, 2'd2, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("pri_fill",  10, 1, 0, 0,  0, 0, 2'd2, 16'h8001, 0, 1, 16'hAAAA));
        vecs.push_back(mk("pri_clr",    1, 1, 1, 3,  1, 1, 2'd2, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("pri_rearm",  1, 1, 1, 1,  0, 0, 2'd3, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("pri_word",   8, 1, 0, 0,  0, 0, 2'd3, 16'h4001, 1, 1, 16'hFFFF));
        vecs.push_back(mk("pri_rd",     1, 1, 0, 0,  1, 0, 2'd0, 16'h4000, 0, 0, 16'h0000));
        vecs.push_back(mk("clr_e",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("af_arm",     1, 1, 1, 2,  0, 0, 2'd1, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("af_fill3",   3, 1, 0, 0,  0, 0, 2'd1, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("af_rearm",   1, 1, 1, 1,  0, 0, 2'd1, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("af_word1",   4, 1, 0, 0,  0, 0, 2'd1, 16'h8001, 0, 1, 16'h5555));
        vecs.push_back(mk("af_word2",   8, 1, 0, 0,  0, 0, 2'd1, 16'h4002, 1, 1, 16'h5555));
        vecs.push_back(mk("clr_f",      1, 1, 0, 0,  0, 1, 2'd0, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("rst_arm",    1, 1, 1, 2,  0, 0, 2'd2, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("rst_fill",   9, 1, 0, 0,  0, 0, 2'd2, 16'h8001, 0, 1, 16'hAAAA));
        vecs.push_back(mk("rst_mid",    1, 0, 0, 0,  0, 0, 2'd2, 16'h0000, 0, 1, 16'h0000));
        vecs.push_back(mk("clamp_arm",  1, 1, 1, 15, 0, 0, 2'd3, 16'h8000, 0, 1, 16'h0000));
        vecs.push_back(mk("clamp_fill",64, 1, 0, 0,  0, 0, 2'd3, 16'h4008, 1, 1, 16'hFFFF));
        vecs.push_back(mk("ovf_rearm",  1, 1, 1, 1,  0, 0, 2'd0, 16'h8008, 0, 1, 16'hFFFF));
        vecs.push_back(mk("ovf_drop",   8, 1, 0, 0,  0, 0, 2'd0, 16'h6008, 1, 1, 16'hFFFF));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst_n;
            for (int j = 0; j < vecs[i].n; j++)
                tick(vecs[i].a, vecs[i].l, vecs[i].r, vecs[i].c, vecs[i].s, 1'b0, "");
            check16({vecs[i].name, ":status"}, status, vecs[i].st);
            check16({vecs[i].name, ":srq"}, 16'(srq), 16'(vecs[i].sq));
            if (vecs[i].chk_dout) check16({vecs[i].name, ":dout"}, dout, vecs[i].d);
        end
        rst = 1'b1;

        // Drain the full FIFO after overflow, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 0, 1, 0, 2'd0, 1'b1, "drain");
            check16("drain_status", status, 16'h6000 | 16'(DEPTH - 1 - i));
            if (i < DEPTH - 1) check16("drain_dout", dout, 16'hFFFF);
            tick(0, 0, 0, 0, 2'd0, 1'b1, "drain_gap");
        end
        tick(0, 0, 1, 0, 2'd0, 1'b1, "drain_udf");
        check16("drain_udf_status", status, 16'h7000);

        // Push and pop on the same edge keep count at one
        tick(0, 0, 0, 1, 2'd0, 1'b1, "pp_clr");
        tick(1, 8, 0, 0, 2'd0, 1'b1, "pp_arm");
        for (int j = 0; j < 64; j++) pp_s[j] = 2'($urandom_range(0, 3));
        for (int w = 0; w < 8; w++) begin
            pp_w[w] = '0;
            for (int b = 0; b < 8; b++) pp_w[w] = pp_w[w] | (16'(pp_s[8 * w + b]) << (2 * b));
        end
        for (int j = 1; j <= 64; j++) begin
            tick(0, 0, (j % 8 == 0) && (j >= 16), 0, pp_s[j - 1], 1'b1, "pp");
            if (j % 8 == 0) begin
                check16("pp_count", 16'(status[10:0]), 16'd1);
                check16("pp_dout", dout, pp_w[j / 8 - 1]);
            end
        end
        check16("pp_final", status, 16'h4001);

        // Randomized traffic, alternating read-heavy and read-starved phases
        tick(0, 0, 0, 1, 2'd0, 1'b1, "rand_clr");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit ra, rr, rc;
            int rl;
            logic [1:0] rs;
            rd_div = ((cyc / 500) % 2 == 0) ? 3 : 40;
            ra = ($urandom_range(0, 19) == 0);
            rl = $urandom_range(0, 15);
            rr = !prev_rd && ($urandom_range(0, rd_div - 1) == 0);
            rc = ($urandom_range(0, 249) == 0);
            rs = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick(ra, rl, rr, rc, rs, 1'b1, "rand");
            prev_rd = rr;
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
